// File: rtl/fifo_uart_tx.sv
// Byte-wide FIFO-fed UART transmitter (8N1, or 8E1 when FIFO_UART_TX_PARITY_EN is defined).
// Pulls one byte per frame from an upstream FIFO with one cycle of read latency.
module fifo_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       fifo_empty_i,
   input  logic [7:0] fifo_data_i,
   output logic       fifo_read_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       frame_done_o
);

   localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStart,
      StData,
`ifdef FIFO_UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        baud_end;

`ifdef FIFO_UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   assign baud_end = (baud_q == BaudMax);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         baud_q   <= 16'd0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d     = parity_q;
`endif
      fifo_read_o  = 1'b0;
      tx_o         = 1'b1;
      busy_o       = 1'b1;
      frame_done_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            busy_o = 1'b0;
            baud_d = 16'd0;
            bit_d  = 3'd0;
            // Gated by reset so a pending byte is never popped during reset.
            if (enable_i && !fifo_empty_i && !rst_i) begin
               fifo_read_o = 1'b1;
               state_d     = StFetch;
            end
         end

         StFetch: begin
            state_d = StLoad;
         end

         StLoad: begin
            shift_d = fifo_data_i;
            bit_d   = 3'd0;
            baud_d  = 16'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d = ^fifo_data_i;
`endif
            state_d = StStart;
         end

         StStart: begin
            tx_o = 1'b0;
            if (baud_end) begin
               baud_d  = 16'd0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         StData: begin
            tx_o = shift_q[0];
            if (baud_end) begin
               baud_d  = 16'd0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

`ifdef FIFO_UART_TX_PARITY_EN
         StParity: begin
            tx_o = parity_q;
            if (baud_end) begin
               baud_d  = 16'd0;
               state_d = StStop;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
`endif

         StStop: begin
            tx_o = 1'b1;
            if (baud_end) begin
               frame_done_o = 1'b1;
               baud_d       = 16'd0;
               state_d      = StIdle;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: directed scenarios plus random bytes, checked
// against a bit-level frame model; honours FIFO_UART_TX_PARITY_EN if defined.
module tb_fifo_uart_tx;

   localparam int unsigned Cpb = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int FrameBits = 11;
`else
   localparam int FrameBits = 10;
`endif
   // Cycles from the read-strobe cycle to the frame_done cycle.
   localparam int LastK = 2 + FrameBits * Cpb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'd0;
   logic       fifo_read;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int n_pass = 0;
   int n_total = 0;
   int n_reads = 0;
   int n_pushed = 0;

   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   logic [7:0] pop_tmp;

   fifo_uart_tx #(
      .CLKS_PER_BIT(Cpb)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (enable),
      .fifo_empty_i(fifo_empty),
      .fifo_data_i (fifo_data),
      .fifo_read_o (fifo_read),
      .tx_o        (tx),
      .busy_o      (busy),
      .frame_done_o(frame_done)
   );

   always #5 clk = ~clk;

   // Upstream FIFO: data appears the cycle after a read strobe, empty flag is registered.
   always @(posedge clk) begin
      if (fifo_read === 1'b1) begin
         n_reads++;
         if (fq.size() > 0) begin
            pop_tmp = fq.pop_front();
            fifo_data <= pop_tmp;
         end
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_byte(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
      n_pushed++;
   endtask

   // Serial value of bit slot p of the frame carrying byte b.
   function automatic logic exp_bit(input logic [7:0] b, input int p);
      if (p == 0) return 1'b0;
      if (p <= 8) return (b >> (p - 1)) & 8'd1;
`ifdef FIFO_UART_TX_PARITY_EN
      if (p == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic wait_read(output int waited);
      waited = 0;
      #1;
      while (fifo_read !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("fetch_strobe", {31'd0, fifo_read}, 32'd1);
      check("fetch_not_empty", {31'd0, fifo_empty}, 32'd0);
      check("fetch_tx_idle", {31'd0, tx}, 32'd1);
      check("fetch_busy_low", {31'd0, busy}, 32'd0);
   endtask

   task automatic run_frame(input int drop_k, input int rst_k);
      logic [7:0] b;
      logic       etx;
      bit         stop;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      stop = 1'b0;
      for (int k = 1; k <= LastK && !stop; k++) begin
         @(negedge clk);
         etx = (k <= 2) ? 1'b1 : exp_bit(b, (k - 3) / int'(Cpb));
         check("tx", {31'd0, tx}, {31'd0, etx});
         check("busy", {31'd0, busy}, 32'd1);
         check("frame_done", {31'd0, frame_done}, {31'd0, (k == LastK)});
         check("no_read_in_frame", {31'd0, fifo_read}, 32'd0);
         if (k == drop_k) enable = 1'b0;
         if (k == rst_k) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_tx", {31'd0, tx}, 32'd1);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_read", {31'd0, fifo_read}, 32'd0);
            check("abort_done", {31'd0, frame_done}, 32'd0);
            rst = 1'b0;
            stop = 1'b1;
         end
      end
   endtask

   task automatic idle_checks(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("idle_tx", {31'd0, tx}, 32'd1);
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_read", {31'd0, fifo_read}, 32'd0);
         check("idle_done", {31'd0, frame_done}, 32'd0);
      end
   endtask

   initial begin
      int w;
      int nb;

      // Reset held with a byte pending and enable high.
      enable = 1'b1;
      push_byte(8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_tx", {31'd0, tx}, 32'd1);
         check("rst_read", {31'd0, fifo_read}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
         check("rst_done", {31'd0, frame_done}, 32'd0);
      end
      rst = 1'b0;

      // Single byte 0xA5.
      wait_read(w);
      run_frame(0, 0);
      idle_checks(3);

      // Back-to-back 0x00, 0xFF with a 3-cycle high gap.
      push_byte(8'h00);
      push_byte(8'hFF);
      wait_read(w);
      run_frame(0, 0);
      wait_read(w);
      check("b2b_gap", w, 32'd1);
      run_frame(0, 0);
      idle_checks(2);

      // Enable dropped in bit 3 of 0x3C; the queued 0x81 must wait.
      push_byte(8'h3C);
      push_byte(8'h81);
      wait_read(w);
      run_frame(3 + 4 * int'(Cpb), 0);
      idle_checks(20);
      enable = 1'b1;
      wait_read(w);
      check("reenable_immediate", w, 32'd0);
      run_frame(0, 0);

      // Reset in bit 5 of 0x5A aborts it; 0x96 then goes out normally.
      push_byte(8'h5A);
      push_byte(8'h96);
      wait_read(w);
      run_frame(0, 3 + 6 * int'(Cpb));
      wait_read(w);
      check("post_reset_fetch", w, 32'd0);
      run_frame(0, 0);

      // 0x07 has odd population, so parity slot (when present) is 1.
      push_byte(8'h07);
      wait_read(w);
      run_frame(0, 0);
      idle_checks(2);

      // Random bytes, one or two queued at a time, random idle spacing.
      for (int i = 0; i < 8; i++) begin
         nb = int'($urandom_range(1, 2));
         for (int j = 0; j < nb; j++) push_byte(8'($urandom));
         for (int j = 0; j < nb; j++) begin
            wait_read(w);
            if (j > 0) check("rand_b2b_gap", w, 32'd1);
            run_frame(0, 0);
         end
         idle_checks(int'($urandom_range(1, 5)));
      end

      check("read_count", n_reads, n_pushed);
      check("fifo_drained", fq.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 clock  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  high permits new bytes to be fetched from the FIFO.
REQ-005 fifo_empty  input  1  FIFO empty flag from the upstream 8-bit FIFO RAM.
REQ-006 fifo_data  input  8  FIFO read data, valid exactly one cycle after a fifo_read pulse.
REQ-007 fifo_read  output  1  one-cycle FIFO read strobe.
REQ-008 tx  output  1  UART serial line, idle high.
REQ-009 busy  output  1  high from the fetch cycle through the last stop-bit cycle.
REQ-010 frame_done  output  1  one-cycle pulse on the final cycle of each stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, LOAD, START, DATA, PARITY (present only with the macro), and STOP.
REQ-012 IDLE: when enable=1 and fifo_empty=0, the block SHALL assert fifo_read for exactly one cycle and go to FETCH; otherwise it SHALL stay in IDLE with tx=1.
REQ-013 FETCH: the block SHALL wait one cycle for FIFO read latency, with fifo_read=0, then go to LOAD.
REQ-014 LOAD: the block SHALL capture fifo_data into an 8-bit shift register, clear the bit counter and baud counter, and go to START.
REQ-015 START: tx SHALL be 0 for CLKS_PER_BIT cycles.
REQ-016 DATA: the block SHALL send 8 bits LSB first, each held for CLKS_PER_BIT cycles, using a 3-bit bit index; after bit 7 it SHALL go to PARITY (macro defined) or STOP.
REQ-017 STOP: tx SHALL be 1 for CLKS_PER_BIT cycles; frame_done SHALL pulse on the last cycle; the next state SHALL be IDLE.
REQ-018 The baud counter SHALL be 16 bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-019 Back-to-back frames: the gap between a stop bit and the next start bit SHALL be exactly 3 cycles at tx=1 (IDLE, FETCH, LOAD).
REQ-020 Deasserting enable mid-frame SHALL NOT abort the frame; the frame SHALL complete, and no further fetch SHALL occur while enable=0.
REQ-021 fifo_empty rising during FETCH or LOAD SHALL be ignored; the fetched byte SHALL be transmitted.
REQ-022 fifo_read SHALL never be asserted outside IDLE, and never while fifo_empty=1.
REQ-023 busy SHALL be 1 in FETCH, LOAD, START, DATA, PARITY, and STOP, and 0 in IDLE.

Reset
REQ-024 While reset=1 at a rising edge, the block SHALL enter IDLE and drive tx=1, fifo_read=0, busy=0, frame_done=0, and clear all counters and the shift register.
REQ-025 Reset mid-frame SHALL abort the frame: tx=1 from the cycle after the reset edge, with no extra fifo_read; the aborted byte is lost.
REQ-026 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-027 Macro FIFO_UART_TX_PARITY_EN, when defined, SHALL add a PARITY state after DATA that drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; the frame is 11 bits.
REQ-028 Without FIFO_UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; the frame is 10 bits (8N1).

Verification (bench uses CLKS_PER_BIT=4)
REQ-029 Reset held 3 cycles with fifo_empty=0 and enable=1 -> tx=1, fifo_read=0, busy=0 throughout reset.
REQ-030 Single byte 0xA5, enable=1 -> one fifo_read pulse; tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; frame_done pulses once; 42 cycles from fifo_read to frame_done.
REQ-031 Two bytes 0x00 and 0xFF queued -> two frames separated by exactly 3 idle-high cycles, with two fifo_read pulses in total.
REQ-032 enable dropped during bit 3 of 0x3C -> the frame completes correctly; no fifo_read follows while fifo_empty=0 and enable=0.
REQ-033 reset pulsed during bit 5 -> tx=1 the next cycle; busy=0; after reset release and enable=1, the next byte is fetched normally.
REQ-034 With FIFO_UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 appears between bit 7 and the stop bit; the frame is 44 cycles long.
